// File: rtl/boot_sequencer_if.sv
// Boot sequencer signal bundle: UART word input, fetch-side address and
// run handshake, program-memory port and sequencer status.
interface boot_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             uart_valid;
    logic [31:0]      uart_data;
    logic [31:0]      fetch_addr;
    logic             run_finished;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic [31:0]      mem_wdata;
    logic             run_en;
    logic             core_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] words_loaded;
    logic             load_error;

    // Sequencer side: owns the memory port and status outputs.
    modport master (
        input  uart_valid, uart_data, fetch_addr, run_finished,
        output mem_addr, mem_we, mem_wdata, run_en, core_flush,
               state, words_loaded, load_error
    );

    // Environment side: UART wrapper, fetch stage and memory.
    modport slave (
        output uart_valid, uart_data, fetch_addr, run_finished,
        input  mem_addr, mem_we, mem_wdata, run_en, core_flush,
               state, words_loaded, load_error
    );
endinterface

// File: rtl/boot_sequencer.sv
// Load-then-run controller: writes UART words into program memory, detects
// the end marker, flushes the pipeline, then lets the core run until fetch
// reports completion. Shares the single memory address port with fetch.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first word of a load or a re-run marker
// LOAD  | writing received words at increasing word addresses
// FLUSH | core_flush held for FLUSH_CYCLES cycles, run_en low
// RUN   | run_en high until run_finished
module boot_sequencer #(
    parameter int          MEM_BYTES    = 4096,
    parameter logic [15:0] END_MARKER   = 16'h1111,
    parameter int          FLUSH_CYCLES = 4,
    parameter int          CNT_W        = 16
) (
    input logic               clk,
    input logic               reset_n,
    boot_sequencer_if.master  bus
);
    // One extra address bit so the "memory full" value MEM_BYTES is representable.
    localparam int AW  = $clog2(MEM_BYTES) + 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [AW-1:0]  LP_LIMIT   = AW'(MEM_BYTES);
    localparam logic [FCW-1:0] LP_FL_LOAD = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_wr_addr;
    logic [AW-1:0]    r_next_addr;
    logic             r_we;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_words;
    logic             r_err;
    logic             r_run_en;
    logic             r_flush;
    logic [FCW-1:0]   r_fcnt;

    logic w_marker;
    logic w_room;

    assign w_marker = (bus.uart_data[15:0] == END_MARKER);
    assign w_room   = (r_next_addr < LP_LIMIT);

    // Sequencer FSM with registered memory-port and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wr_addr   <= '0;
            r_next_addr <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_words     <= '0;
            r_err       <= 1'b0;
            r_run_en    <= 1'b0;
            r_flush     <= 1'b0;
            r_fcnt      <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.uart_valid) begin
                        if (!w_marker) begin
                            r_wr_addr   <= '0;
                            r_next_addr <= AW'(4);
                            r_wdata     <= bus.uart_data;
                            r_we        <= 1'b1;
                            r_words     <= CNT_W'(1);
                            r_err       <= 1'b0;
                            r_state     <= ST_LOAD;
                        end else if (r_words != '0) begin
                            // Re-run the image already in memory.
                            r_state <= ST_FLUSH;
                            r_flush <= 1'b1;
                            r_fcnt  <= LP_FL_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.uart_valid) begin
                        if (w_marker) begin
                            r_state <= ST_FLUSH;
                            r_flush <= 1'b1;
                            r_fcnt  <= LP_FL_LOAD;
                        end else if (w_room) begin
                            r_wr_addr   <= r_next_addr;
                            r_next_addr <= r_next_addr + AW'(4);
                            r_wdata     <= bus.uart_data;
                            r_we        <= 1'b1;
                            if (r_words != '1) begin
                                r_words <= r_words + CNT_W'(1);
                            end
                        end else begin
                            // Memory full: drop the word, never wrap.
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (bus.uart_valid) begin
                        r_err <= 1'b1;
                    end
                    if (r_fcnt == '0) begin
                        r_state  <= ST_RUN;
                        r_flush  <= 1'b0;
                        r_run_en <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt - FCW'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.uart_valid) begin
                        r_err <= 1'b1;
                    end
                    if (bus.run_finished) begin
                        r_state  <= ST_IDLE;
                        r_run_en <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_run_en <= 1'b0;
                    r_flush  <= 1'b0;
                end
            endcase
        end
    end

    // The write address only owns the memory port during a loader write.
    assign bus.mem_addr     = r_we ? 32'(r_wr_addr) : bus.fetch_addr;
    assign bus.mem_we       = r_we;
    assign bus.mem_wdata    = r_wdata;
    assign bus.run_en       = r_run_en;
    assign bus.core_flush   = r_flush;
    assign bus.state        = r_state;
    assign bus.words_loaded = r_words;
    assign bus.load_error   = r_err;
endmodule
